// File: rtl/dcache_line_mem.sv
// Line-granular backing memory for the L1 dcache: answers 128-bit line fills and
// writebacks over ready/valid with a fixed programmable response latency.
module dcache_line_mem #(
  parameter int unsigned LINE_IDX_W = 12,
  parameter int unsigned LATENCY    = 4
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic [31:0]  read_addr,
  input  logic         read_addr_valid,
  output logic         read_addr_ready,
  output logic [127:0] read_data,
  output logic         read_data_valid,
  input  logic [31:0]  write_addr,
  input  logic         write_addr_valid,
  input  logic [127:0] write_data,
  output logic         write_addr_ready,
  output logic         write_resp_valid,
  output logic         busy
);

  localparam int unsigned LINES  = 1 << LINE_IDX_W;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_WAIT,
    S_WRITE_WAIT,
    S_READ_RESP,
    S_WRITE_RESP
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [LINE_IDX_W-1:0]   r_idx;
  logic [LINE_W-1:0]       r_wdata;
  logic [LINE_W-1:0]       r_rdata;
  logic                    r_ready;
  logic                    r_busy;
  logic                    r_rdv;
  logic                    r_wrv;

  // Contents start at zero and survive RESET; loaded image for FPGA builds.
  logic [LINE_W-1:0]       r_mem [LINES] = '{default: '0};

  logic [LINE_IDX_W-1:0]   w_rd_idx;
  logic [LINE_IDX_W-1:0]   w_wr_idx;
  logic                    w_unused_addr;

  assign w_rd_idx = read_addr[LINE_IDX_W+3:4];
  assign w_wr_idx = write_addr[LINE_IDX_W+3:4];
  // Offset and alias bits of the addresses are intentionally dropped.
  assign w_unused_addr = ^{read_addr, write_addr};

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_rdv   <= 1'b0;
      r_wrv   <= 1'b0;
    end else begin
      r_rdv <= 1'b0;
      r_wrv <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          // Write wins so a writeback lands before the fill that follows it.
          if (write_addr_valid) begin
            r_idx   <= w_wr_idx;
            r_wdata <= write_data;
            r_cnt   <= CNT_LOAD;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            if (LATENCY == 1) begin
              r_state <= S_WRITE_RESP;
              r_wrv   <= 1'b1;
            end else begin
              r_state <= S_WRITE_WAIT;
            end
          end else if (read_addr_valid) begin
            r_idx   <= w_rd_idx;
            r_cnt   <= CNT_LOAD;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            if (LATENCY == 1) begin
              r_state <= S_READ_RESP;
              r_rdv   <= 1'b1;
              r_rdata <= r_mem[w_rd_idx];
            end else begin
              r_state <= S_READ_WAIT;
            end
          end
        end
        // Counter reaches zero on entry to the response state.
        S_READ_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_READ_RESP;
            r_rdv   <= 1'b1;
            r_rdata <= r_mem[r_idx];
          end
        end
        S_WRITE_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_WRITE_RESP;
            r_wrv   <= 1'b1;
          end
        end
        S_READ_RESP, S_WRITE_RESP: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Commit at the end of the write response cycle; a reset drops it.
  always_ff @(posedge clk) begin
    if (!RESET && r_state == S_WRITE_RESP) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign read_addr_ready  = r_ready;
  assign write_addr_ready = r_ready;
  assign read_data        = r_rdata;
  assign read_data_valid  = r_rdv;
  assign write_resp_valid = r_wrv;
  assign busy             = r_busy;

endmodule
